// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_add.sv
// Existing single-bit half-adder cell of the datapath.
module half_add (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first,
// built from two half_add cells and a carry register, with start/done handshake.
module serial_add_ctrl
   import add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
   logic [CW-1:0]    cnt;
   logic             cr;
   logic             s0, c0, s, c1, cr_nxt;

   half_add ha0 (.a(sa[0]), .b(sb[0]), .s(s0), .c(c0));
   half_add ha1 (.a(s0),    .b(cr),    .s(s),  .c(c1));

   assign cr_nxt = c0 | c1;

   // Shift-then-insert form stays legal when WIDTH is 1.
   always_comb begin
      sr_nxt            = sr >> 1;
      sr_nxt[WIDTH-1]   = s;
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         carry <= 1'b0;
         sa    <= '0;
         sb    <= '0;
         sr    <= '0;
         cr    <= 1'b0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sr    <= '0;
                  cr    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sr  <= sr_nxt;
               cr  <= cr_nxt;
               cnt <= cnt + CW'(1);
               // Last bit step: publish this edge's bit and carry directly.
               if (cnt == LAST) begin
                  sum   <= sr_nxt;
                  carry <= cr_nxt;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: table-driven adds at WIDTH=8 plus
// directed sequences for ignored starts, mid-run reset and WIDTH=1.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, carry;
   logic [7:0] sum;

   logic       start1;
   logic [0:0] a1, b1, sum1;
   logic       busy1, done1, carry1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .carry(carry)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
   );

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] exp_sum;
      logic       exp_carry;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one add at WIDTH=8 and checks latency, result, busy length and done count.
   task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] exp_s, input logic exp_c, input string tag);
      int  lat;
      int  busy_cycles;
      int  dones;
      bit  seen;
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("%s busy_at_start", tag), busy, 1);
      lat = 0; seen = 0; busy_cycles = 1; dones = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (busy) busy_cycles++;
         if (done) begin
            dones++;
            if (!seen) begin
               seen = 1;
               lat  = k;
               check($sformatf("%s sum", tag), sum, exp_s);
               check($sformatf("%s carry", tag), carry, exp_c);
            end
         end
         if (!busy) break;
      end
      check($sformatf("%s latency", tag), lat, 8);
      check($sformatf("%s busy_cycles", tag), busy_cycles, 9);
      check($sformatf("%s done_count", tag), dones, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int dones;
      int bc;

      vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
      vecs[5] = '{8'hC8, 8'h64, 8'h2C, 1'b1};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("idle%0d busy", i), busy, 0);
         check($sformatf("idle%0d done", i), done, 0);
         check($sformatf("idle%0d sum", i), sum, 0);
         check($sformatf("idle%0d carry", i), carry, 0);
      end

      for (int i = 0; i < 6; i++)
         run_add(vecs[i].va, vecs[i].vb, vecs[i].exp_sum, vecs[i].exp_carry,
                 $sformatf("vec%0d", i));

      // Start mid-RUN is ignored; previous result (0x2C/1) held until completion
      @(negedge clk);
      a = 8'h12; b = 8'h34; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0; a = 8'h0F; b = 8'hF0;
      check("ign held_sum", sum, 8'h2C);
      check("ign held_carry", carry, 1);
      check("ign no_early_done", done, 0);
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done) begin
            dones++;
            check("ign sum", sum, 8'h46);
            check("ign carry", carry, 0);
         end
         if (!busy) break;
      end
      check("ign done_count", dones, 1);
      bc = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (busy || done) bc++;
      end
      check("ign no_second_run", bc, 0);

      // Reset at bit step 4 aborts immediately
      @(negedge clk);
      a = 8'h77; b = 8'h11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst busy_before", busy, 1);
      check("rst sum_held", sum, 8'h46);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst sum", sum, 0);
      check("rst carry", carry, 0);
      dones = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("rst no_done", dones, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_add(8'h01, 8'h02, 8'h03, 1'b0, "post_rst");

      // WIDTH=1: done one cycle after start
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("w1 busy_at_start", busy1, 1);
      check("w1 done_at_start", done1, 0);
      @(posedge clk); #1;
      check("w1 done", done1, 1);
      check("w1 sum", sum1, 0);
      check("w1 carry", carry1, 1);
      @(posedge clk); #1;
      check("w1 done_drop", done1, 0);
      check("w1 busy_drop", busy1, 0);
      check("w1 sum_hold", sum1, 0);
      check("w1 carry_hold", carry1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
